// File: rtl/data_debounce_pkg.sv
// data_debounce_pkg
// Shared types and default constants for the data_debounce block.
//   state_t             : qualification FSM state encoding
//   DEBOUNCE_CYCLES_DEF : default number of consecutive samples to accept a level
//   GLITCH_WIDTH_DEF    : default width of the saturating glitch counter
package data_debounce_pkg;

    typedef enum logic [0:0] {
        ST_STABLE,
        ST_CHECK
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int GLITCH_WIDTH_DEF    = 8;

endpackage : data_debounce_pkg

// File: rtl/data_debounce.sv
// data_debounce
// Filters bounce on a synchronized single-bit input. A new level must be seen
// on DEBOUNCE_CYCLES consecutive rising edges before it is accepted.
// Ports:
//   clk_i        : system clock, rising edge
//   rst_i        : synchronous active-high reset
//   data_i       : synchronized input (from data_sync)
//   data_o       : debounced level, registered
//   rise_o       : one-cycle pulse while data_o first shows a 0->1 change
//   fall_o       : one-cycle pulse while data_o first shows a 1->0 change
//   busy_o       : high while a candidate level is being qualified
//   glitch_cnt_o : saturating count of aborted qualifications
module data_debounce
    import data_debounce_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic RESET_LEVEL     = 1'b0,
    parameter int   GLITCH_WIDTH    = GLITCH_WIDTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    data_i,
    output logic                    data_o,
    output logic                    rise_o,
    output logic                    fall_o,
    output logic                    busy_o,
    output logic [GLITCH_WIDTH-1:0] glitch_cnt_o
);

    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value at which the current sample completes qualification.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_STABLE;
            cnt          <= '0;
            data_o       <= RESET_LEVEL;
            rise_o       <= 1'b0;
            fall_o       <= 1'b0;
            busy_o       <= 1'b0;
            glitch_cnt_o <= '0;
        end else begin
            // Edge pulses last exactly one cycle unless re-armed below.
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            case (state)
                ST_STABLE: begin
                    if (data_i != data_o) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // Single-sample qualification: accept straight away.
                            data_o <= data_i;
                            rise_o <= data_i;
                            fall_o <= ~data_i;
                        end else begin
                            // This edge's sample is the first of the run.
                            cnt    <= CNT_WIDTH'(1);
                            state  <= ST_CHECK;
                            busy_o <= 1'b1;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_CHECK: begin
                    if (data_i != data_o) begin
                        if (cnt == CNT_LAST) begin
                            // Acceptance uses the sample taken at this edge.
                            data_o <= data_i;
                            rise_o <= data_i;
                            fall_o <= ~data_i;
                            cnt    <= '0;
                            state  <= ST_STABLE;
                            busy_o <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_WIDTH'(1);
                        end
                    end else begin
                        // Input fell back before qualifying: count a glitch.
                        cnt    <= '0;
                        state  <= ST_STABLE;
                        busy_o <= 1'b0;
                        if (glitch_cnt_o != '1)
                            glitch_cnt_o <= glitch_cnt_o + GLITCH_WIDTH'(1);
                    end
                end
                default: begin
                    state  <= ST_STABLE;
                    cnt    <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule : data_debounce

// File: tb/tb_data_debounce.sv
// tb_data_debounce
// Directed bench: one DEBOUNCE_CYCLES=4 instance and one DEBOUNCE_CYCLES=1
// instance share clock and reset. Inputs change 1 time unit after a rising
// edge; outputs are sampled 1 time unit after the following rising edge.
module tb_data_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic       d4, q4, r4, f4, b4;
    logic [7:0] g4;
    logic       d1, q1, r1, f1, b1;
    logic [7:0] g1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    data_debounce #(.DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0), .GLITCH_WIDTH(8)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .data_i(d4), .data_o(q4),
        .rise_o(r4), .fall_o(f4), .busy_o(b4), .glitch_cnt_o(g4)
    );

    data_debounce #(.DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0), .GLITCH_WIDTH(8)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .data_i(d1), .data_o(q1),
        .rise_o(r1), .fall_o(f1), .busy_o(b1), .glitch_cnt_o(g1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Snapshot of the DC=4 instance's outputs: {data, rise, fall, busy}.
    function automatic logic [3:0] o4();
        return {q4, r4, f4, b4};
    endfunction

    initial begin
        int pulses;
        rst = 1'b1;
        d4  = 1'b1;
        d1  = 1'b0;

        // Reset held for 3 clocks with data_i=1.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_outs", o4(), 4'b0000);
            chk("reset_glitch", g4, 0);
        end
        rst = 1'b0;
        d4  = 1'b0;
        tick();
        chk("idle", o4(), 4'b0000);

        // Clean rise: busy for 3 cycles, data_o and rise on the 4th edge.
        d4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rise_qual", o4(), 4'b0001);
        end
        tick();
        chk("rise_accept", o4(), 4'b1100);
        tick();
        chk("rise_after", o4(), 4'b1000);

        // Clean fall.
        d4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fall_qual", o4(), 4'b1001);
        end
        tick();
        chk("fall_accept", o4(), 4'b0010);
        tick();
        chk("fall_after", o4(), 4'b0000);

        // Single glitch: two samples high then back low.
        d4 = 1'b1;
        tick();
        tick();
        chk("glitch_busy", o4(), 4'b0001);
        d4 = 1'b0;
        tick();
        chk("glitch_outs", o4(), 4'b0000);
        chk("glitch_one", g4, 1);

        // 299 more glitches: counter saturates at 255, no pulses ever.
        pulses = 0;
        for (int i = 0; i < 299; i++) begin
            d4 = 1'b1;
            tick();
            pulses += int'(r4) + int'(f4);
            tick();
            pulses += int'(r4) + int'(f4);
            d4 = 1'b0;
            tick();
            pulses += int'(r4) + int'(f4);
        end
        chk("glitch_sat", g4, 255);
        chk("glitch_level", q4, 0);
        chk("glitch_pulses", pulses, 0);

        // Rise again so reset has a visible effect on data_o.
        d4 = 1'b1;
        repeat (4) tick();
        chk("rerise", o4(), 4'b1100);
        chk("rerise_sat", g4, 255);

        // Reset while cnt=2 in ST_CHECK.
        d4 = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", o4(), 4'b1001);
        rst = 1'b1;
        d4  = 1'b1;
        tick();
        chk("mid_rst_outs", o4(), 4'b0000);
        chk("mid_rst_glitch", g4, 0);

        // After release a held 1 needs a full 4 new cycles.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_qual", o4(), 4'b0001);
        end
        tick();
        chk("post_rst_accept", o4(), 4'b1100);

        // DEBOUNCE_CYCLES=1 instance: follows input with one-cycle delay.
        chk("dc1_idle", {q1, r1, f1, b1}, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            d1 = 1'b1;
            tick();
            chk("dc1_rise", {q1, r1, f1, b1}, 4'b1100);
            d1 = 1'b0;
            tick();
            chk("dc1_fall", {q1, r1, f1, b1}, 4'b0010);
        end
        chk("dc1_glitch", g1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_data_debounce
